uart: RTL and testbench

UART -- requirements
Module: uart

---
 rtl/uart.sv | 193 +++++++++++++++++++
 tb/tb_uart.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart
//  Description : 8N1 full-duplex UART with a synchronized receiver and a
//                sticky received-byte flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic       TX,
    input  logic       TX_START,
    input  logic [7:0] TX_DATA,
    output logic [7:0] RX_DATA,
    output logic       value_intr,
    input  logic       ACK
);

    localparam int             CPB       = CLK_FREQ / BAUD;
    localparam int             CW        = $clog2(CPB);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CPB / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // ------------------------------------------------------------------ RX
    state_t          rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_idx_q, rx_idx_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_s1_q, rx_s2_q;
    logic            rx_done;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            // Synchronizer resets to the idle level so release never looks like a start edge
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_s1_q    <= RX;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                rx_idx_d = '0;
                if (!rx_s2_q) rx_state_d = S_START;
            end
            S_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
                    else                  rx_idx_d   = rx_idx_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_IDLE;
                    rx_done    = rx_s2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
        // A completing byte takes priority over a coincident acknowledge
        rx_data_d  = rx_done ? rx_shift_q : rx_data_q;
        rx_valid_d = rx_done ? 1'b1 : (ACK ? 1'b0 : rx_valid_q);
    end

    assign RX_DATA    = rx_data_q;
    assign value_intr = rx_valid_q;

    // ------------------------------------------------------------------ TX
    state_t          tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_idx_q, tx_idx_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            tx_q, tx_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d = '0;
                tx_idx_d = '0;
                tx_d     = 1'b1;
                if (TX_START) begin
                    tx_shift_d = TX_DATA;
                    tx_d       = 1'b0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = S_STOP;
                    end else begin
                        tx_idx_d   = tx_idx_q + 3'd1;
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    assign TX = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart
//  Description : Directed self-checking bench for the 8N1 UART (CPB = 10).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int CPB      = 10;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX;
    logic       TX;
    logic       TX_START;
    logic [7:0] TX_DATA;
    logic [7:0] RX_DATA;
    logic       value_intr;
    logic       ACK;

    int n_checks = 0;
    int n_errors = 0;
    int rx_lat   = 98;

    always #5 CLK = ~CLK;

    uart #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX         (RX),
        .TX         (TX),
        .TX_START   (TX_START),
        .TX_DATA    (TX_DATA),
        .RX_DATA    (RX_DATA),
        .value_intr (value_intr),
        .ACK        (ACK)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    // Drives the first ncyc clocks of an 8N1 frame onto RX
    task automatic drive_rx(input logic [7:0] data, input logic stop, input int ncyc);
        logic [9:0] frm;
        frm = {stop, data, 1'b0};
        for (int i = 0; i < ncyc; i++) begin
            RX = frm[i / CPB];
            @(posedge CLK); #1;
        end
    endtask

    task automatic rx_idle(input int n);
        RX = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic tx_frame(input logic [7:0] data, input bit poke);
        logic [9:0] frm;
        frm      = {1'b1, data, 1'b0};
        TX_DATA  = data;
        TX_START = 1'b1;
        @(posedge CLK); #1;
        TX_START = 1'b0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
                n_checks++;
                if (TX !== frm[b]) begin
                    n_errors++;
                    $display("FAIL tx_bit%0d_cyc%0d: TX=%b expected %b", b, c, TX, frm[b]);
                end
                if (poke && b == 3 && c == 2) begin
                    TX_START = 1'b1;
                    TX_DATA  = ~data;
                end else begin
                    TX_START = 1'b0;
                end
                @(posedge CLK); #1;
            end
        end
        TX_START = 1'b0;
        for (int c = 0; c < 15; c++) begin
            n_checks++;
            if (TX !== 1'b1) begin
                n_errors++;
                $display("FAIL tx_idle_after_frame cyc%0d: TX=%b expected 1", c, TX);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset;
        RX = 1'b1; TX_START = 1'b0; TX_DATA = 8'h00; ACK = 1'b0;
        RST = 1'b1;
        #1;
        RST = 1'b0;
        #1;
        n_checks++;
        if (TX !== 1'b1) begin n_errors++; $display("FAIL reset_tx: TX=%b expected 1", TX); end
        n_checks++;
        if (value_intr !== 1'b0) begin n_errors++; $display("FAIL reset_intr: value_intr=%b expected 0", value_intr); end
        n_checks++;
        if (RX_DATA !== 8'h00) begin n_errors++; $display("FAIL reset_rxdata: RX_DATA=%h expected 00", RX_DATA); end
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        rx_idle(5);
    endtask

    task automatic test_rx_basic;
        int n;
        bit seen;
        n = 0; seen = 1'b0;
        fork
            drive_rx(8'h2B, 1'b1, 100);
            begin
                for (int i = 0; i < 150 && !seen; i++) begin
                    @(posedge CLK); #1;
                    n++;
                    if (value_intr === 1'b1) seen = 1'b1;
                end
            end
        join
        n_checks++;
        if (!seen || n < 90 || n > 100) begin
            n_errors++;
            $display("FAIL rx_latency: seen=%0d after %0d clocks expected about 95", seen, n);
        end else begin
            rx_lat = n;
        end
        rx_idle(5);
        n_checks++;
        if (RX_DATA !== 8'h2B) begin n_errors++; $display("FAIL rx_2b_data: RX_DATA=%h expected 2b", RX_DATA); end
        n_checks++;
        if (value_intr !== 1'b1) begin n_errors++; $display("FAIL rx_2b_held: value_intr=%b expected 1", value_intr); end
        ACK = 1'b1;
        @(posedge CLK); #1;
        ACK = 1'b0;
        n_checks++;
        if (value_intr !== 1'b0) begin n_errors++; $display("FAIL rx_ack_clear: value_intr=%b expected 0", value_intr); end
        ACK = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        ACK = 1'b0;
        n_checks++;
        if (value_intr !== 1'b0 || RX_DATA !== 8'h2B) begin
            n_errors++;
            $display("FAIL rx_ack_idle: value_intr=%b RX_DATA=%h expected 0 2b", value_intr, RX_DATA);
        end
    endtask

    task automatic test_tx;
        tx_frame(8'hA5, 1'b1);
    endtask

    task automatic test_rx_errors;
        RX = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        rx_idle(30);
        n_checks++;
        if (value_intr !== 1'b0) begin n_errors++; $display("FAIL rx_glitch: value_intr=%b expected 0", value_intr); end
        drive_rx(8'h37, 1'b0, 100);
        rx_idle(30);
        n_checks++;
        if (value_intr !== 1'b0) begin n_errors++; $display("FAIL rx_framing_intr: value_intr=%b expected 0", value_intr); end
        n_checks++;
        if (RX_DATA !== 8'h2B) begin n_errors++; $display("FAIL rx_framing_data: RX_DATA=%h expected 2b", RX_DATA); end
    endtask

    task automatic test_overrun;
        drive_rx(8'h05, 1'b1, 100);
        rx_idle(5);
        n_checks++;
        if (value_intr !== 1'b1 || RX_DATA !== 8'h05) begin
            n_errors++;
            $display("FAIL ovr_first: value_intr=%b RX_DATA=%h expected 1 05", value_intr, RX_DATA);
        end
        drive_rx(8'h03, 1'b1, 100);
        rx_idle(5);
        n_checks++;
        if (value_intr !== 1'b1 || RX_DATA !== 8'h03) begin
            n_errors++;
            $display("FAIL ovr_second: value_intr=%b RX_DATA=%h expected 1 03", value_intr, RX_DATA);
        end
        // ACK lands exactly on the edge where the third byte completes
        fork
            drive_rx(8'h78, 1'b1, 100);
            begin
                repeat (rx_lat - 1) @(posedge CLK);
                #1;
                ACK = 1'b1;
                @(posedge CLK); #1;
                ACK = 1'b0;
            end
        join
        n_checks++;
        if (value_intr !== 1'b1 || RX_DATA !== 8'h78) begin
            n_errors++;
            $display("FAIL ack_collision: value_intr=%b RX_DATA=%h expected 1 78", value_intr, RX_DATA);
        end
        rx_idle(3);
        n_checks++;
        if (value_intr !== 1'b1) begin n_errors++; $display("FAIL ack_collision_hold: value_intr=%b expected 1", value_intr); end
        ACK = 1'b1;
        @(posedge CLK); #1;
        ACK = 1'b0;
        n_checks++;
        if (value_intr !== 1'b0) begin n_errors++; $display("FAIL ovr_ack: value_intr=%b expected 0", value_intr); end
    endtask

    task automatic test_reset_midframe;
        bit bad;
        bad      = 1'b0;
        TX_DATA  = 8'h00;
        TX_START = 1'b1;
        fork
            drive_rx(8'hC3, 1'b1, 45);
            begin
                @(posedge CLK); #1;
                TX_START = 1'b0;
            end
        join
        n_checks++;
        if (TX !== 1'b0) begin n_errors++; $display("FAIL mid_tx_busy: TX=%b expected 0", TX); end
        RST = 1'b0;
        RX  = 1'b1;
        #1;
        n_checks++;
        if (TX !== 1'b1) begin n_errors++; $display("FAIL mid_reset_tx: TX=%b expected 1", TX); end
        n_checks++;
        if (value_intr !== 1'b0 || RX_DATA !== 8'h00) begin
            n_errors++;
            $display("FAIL mid_reset_rx: value_intr=%b RX_DATA=%h expected 0 00", value_intr, RX_DATA);
        end
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if (TX !== 1'b1 || value_intr !== 1'b0) bad = 1'b1;
            @(posedge CLK); #1;
        end
        n_checks++;
        if (bad) begin n_errors++; $display("FAIL mid_quiet: TX or value_intr active after reset, TX=%b intr=%b expected 1 0", TX, value_intr); end
        fork
            tx_frame(8'h3C, 1'b0);
            drive_rx(8'hC3, 1'b1, 100);
        join
        rx_idle(5);
        n_checks++;
        if (value_intr !== 1'b1 || RX_DATA !== 8'hC3) begin
            n_errors++;
            $display("FAIL mid_recover_rx: value_intr=%b RX_DATA=%h expected 1 c3", value_intr, RX_DATA);
        end
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_tx();
        test_rx_errors();
        test_overrun();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
